// File: rtl/tohost_monitor_if.sv
// Store-bus snoop and verdict/status bundle shared by the simulation top and tohost_monitor.
// The core side drives the store/retire signals; the monitor drives the status signals.
interface tohost_monitor_if #(
  parameter int unsigned CNT_W = 32
);
  logic             st_valid;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [3:0]       st_mask;
  logic             retire;

  logic             done;
  logic             pass;
  logic             timeout;
  logic [30:0]      fail_code;
  logic             bad_write;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instret_count;
  logic             halt_req;

  modport master (
    output st_valid, st_addr, st_data, st_mask, retire,
    input  done, pass, timeout, fail_code, bad_write,
    input  cycle_count, instret_count, halt_req
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_mask, retire,
    output done, pass, timeout, fail_code, bad_write,
    output cycle_count, instret_count, halt_req
  );
endinterface

// File: rtl/tohost_monitor.sv
// Passive riscv-tests "tohost" decoder: turns the test's result store into a pass/fail/timeout
// verdict, counts cycles and retired instructions while running, and requests a halt on verdict.
module tohost_monitor #(
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int unsigned TIMEOUT     = 5000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic           clk,
  input  logic           rst,
  tohost_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(TIMEOUT - 1);
  localparam logic [30:0]      CODE_NOT_A_RESULT = 31'h7FFF_FFFF;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_pass;
  logic             w_pass_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic [30:0]      r_fail_code;
  logic [30:0]      w_fail_code_nxt;
  logic             r_bad_write;
  logic             w_bad_write_nxt;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] w_cycle_nxt;
  logic [CNT_W-1:0] r_instret;
  logic [CNT_W-1:0] w_instret_nxt;

  logic             w_hit;
  logic             w_full_hit;
  logic             w_partial_hit;
  logic             w_expire;
  logic             w_unused_addr_lsbs;

  // Byte offset within the tohost word does not matter; only the word address is matched.
  assign w_hit              = bus.st_valid && (bus.st_addr[31:2] == TOHOST_ADDR[31:2]);
  assign w_full_hit         = w_hit && (bus.st_mask == 4'b1111);
  assign w_partial_hit      = w_hit && (bus.st_mask != 4'b1111) && (bus.st_mask != 4'b0000);
  assign w_expire           = (r_cycle == EXPIRE_AT);
  assign w_unused_addr_lsbs = ^bus.st_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_fail_code <= '0;
      r_bad_write <= 1'b0;
      r_cycle     <= '0;
      r_instret   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pass      <= w_pass_nxt;
      r_timeout   <= w_timeout_nxt;
      r_fail_code <= w_fail_code_nxt;
      r_bad_write <= w_bad_write_nxt;
      r_cycle     <= w_cycle_nxt;
      r_instret   <= w_instret_nxt;
    end
  end

  // Terminal states hold everything; only RUN looks at the bus. A full hit beats the watchdog.
  always_comb begin
    w_state_nxt     = r_state;
    w_pass_nxt      = r_pass;
    w_timeout_nxt   = r_timeout;
    w_fail_code_nxt = r_fail_code;
    w_bad_write_nxt = r_bad_write;
    w_cycle_nxt     = r_cycle;
    w_instret_nxt   = r_instret;

    if (r_state == ST_RUN) begin
      if (r_cycle != CNT_MAX) begin
        w_cycle_nxt = r_cycle + CNT_W'(1);
      end
      if (bus.retire && (r_instret != CNT_MAX)) begin
        w_instret_nxt = r_instret + CNT_W'(1);
      end
      if (w_partial_hit) begin
        w_bad_write_nxt = 1'b1;
      end

      if (w_full_hit) begin
        if (bus.st_data == 32'h0000_0001) begin
          w_state_nxt = ST_PASS;
          w_pass_nxt  = 1'b1;
        end else begin
          // An even value is a syscall/unsupported request rather than a test number.
          w_state_nxt     = ST_FAIL;
          w_fail_code_nxt = bus.st_data[0] ? bus.st_data[31:1] : CODE_NOT_A_RESULT;
        end
      end else if (w_expire) begin
        w_state_nxt   = ST_TIMEOUT;
        w_timeout_nxt = 1'b1;
      end
    end
  end

  assign bus.done          = (r_state != ST_RUN);
  assign bus.halt_req      = (r_state != ST_RUN);
  assign bus.pass          = r_pass;
  assign bus.timeout       = r_timeout;
  assign bus.fail_code     = r_fail_code;
  assign bus.bad_write     = r_bad_write;
  assign bus.cycle_count   = r_cycle;
  assign bus.instret_count = r_instret;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && (r_state == ST_RUN) && $isunknown(bus.st_valid)) begin
      $error("tohost_monitor: st_valid is unknown while running");
    end
  end
`endif

endmodule

// File: tb/tb_tohost_monitor.sv
// Self-checking bench for tohost_monitor: directed riscv-tests scenarios followed by random
// store traffic, all compared against a verdict-level reference model.
module tb_tohost_monitor;

  localparam int unsigned TIMEOUT  = 20;
  localparam int unsigned CNT_W    = 32;
  localparam logic [31:0] TOHOST   = 32'h0000_1000;
  localparam longint      CNT_SAT  = 64'h0000_0000_FFFF_FFFF;

  typedef enum int {V_RUNNING, V_PASSED, V_FAILED, V_TIMED_OUT} verdict_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  tohost_monitor_if #(.CNT_W(CNT_W)) bus ();

  tohost_monitor #(
    .TOHOST_ADDR (TOHOST),
    .TIMEOUT     (TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  verdict_t    mVerdict;
  logic [30:0] mFailCode;
  bit          mBadWrite;
  longint      mCycles;
  longint      mRetired;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".done"},      64'(bus.done),          64'(mVerdict != V_RUNNING));
    check({tag, ".halt_req"},  64'(bus.halt_req),      64'(mVerdict != V_RUNNING));
    check({tag, ".pass"},      64'(bus.pass),          64'(mVerdict == V_PASSED));
    check({tag, ".timeout"},   64'(bus.timeout),       64'(mVerdict == V_TIMED_OUT));
    check({tag, ".fail_code"}, 64'(bus.fail_code),     64'(mFailCode));
    check({tag, ".bad_write"}, 64'(bus.bad_write),     64'(mBadWrite));
    check({tag, ".cycles"},    64'(bus.cycle_count),   64'(mCycles));
    check({tag, ".instret"},   64'(bus.instret_count), 64'(mRetired));
  endtask

  // Reference model: one call per clock spent with the given bus values, reasoning in verdicts.
  task automatic modelCycle(input bit valid, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] mask, input bit ret);
    bit toTohost;
    if (mVerdict != V_RUNNING) return;
    toTohost = valid && ((addr >> 2) == (TOHOST >> 2));
    if (toTohost && mask == 4'hF) begin
      if (data == 32'd1) mVerdict = V_PASSED;
      else begin
        mVerdict  = V_FAILED;
        mFailCode = (data % 2 == 1) ? 31'(data / 2) : 31'h7FFF_FFFF;
      end
    end else if (mCycles + 1 == longint'(TIMEOUT)) begin
      mVerdict = V_TIMED_OUT;
    end
    if (toTohost && mask != 4'hF && mask != 4'h0) mBadWrite = 1'b1;
    mCycles  = (mCycles + 1 > CNT_SAT) ? CNT_SAT : mCycles + 1;
    if (ret) mRetired = (mRetired + 1 > CNT_SAT) ? CNT_SAT : mRetired + 1;
  endtask

  task automatic applyStimulus(input bit valid, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] mask, input bit ret);
    bus.st_valid = valid;
    bus.st_addr  = addr;
    bus.st_data  = data;
    bus.st_mask  = mask;
    bus.retire   = ret;
    modelCycle(valid, addr, data, mask, ret);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit ret, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, ret);
      checkOutput(tag);
    end
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock.
  task automatic doReset(input string tag);
    rst = 1'b1;
    #1;
    mVerdict  = V_RUNNING;
    mFailCode = '0;
    mBadWrite = 1'b0;
    mCycles   = 0;
    mRetired  = 0;
    checkOutput(tag);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rAddr;
    logic [31:0] rData;
    logic [3:0]  rMask;

    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.st_mask  = '0;
    bus.retire   = 1'b0;
    @(posedge clk);
    #1;
    doReset("reset");

    // Directed pass, then later stores must not disturb the verdict.
    idle(10, 1'b1, "pass.idle");
    applyStimulus(1'b1, 32'h1000, 32'h1, 4'hF, 1'b1);
    checkOutput("pass.hit");
    check("pass.cycle11", 64'(bus.cycle_count), 64'd11);
    applyStimulus(1'b1, 32'h1000, 32'h7, 4'hF, 1'b1);
    checkOutput("pass.after");
    idle(2, 1'b1, "pass.frozen");

    doReset("fail.reset");
    applyStimulus(1'b1, 32'h1000, 32'h7, 4'hF, 1'b0);
    checkOutput("fail.code3");
    check("fail.code3.const", 64'(bus.fail_code), 64'd3);
    doReset("fail2.reset");
    applyStimulus(1'b1, 32'h1000, 32'h4, 4'hF, 1'b0);
    checkOutput("fail.even");
    check("fail.even.const", 64'(bus.fail_code), 64'h7FFF_FFFF);
    doReset("fail3.reset");
    applyStimulus(1'b1, 32'h1000, 32'h0, 4'hF, 1'b0);
    checkOutput("fail.zero");

    // Neighbouring address and partial-width stores must not end the run.
    doReset("filt.reset");
    applyStimulus(1'b1, 32'h1004, 32'h1, 4'hF, 1'b0);
    checkOutput("filt.other");
    applyStimulus(1'b1, 32'h1000, 32'h1, 4'b0011, 1'b0);
    checkOutput("filt.partial");
    check("filt.bad.const", 64'(bus.bad_write), 64'd1);
    applyStimulus(1'b1, 32'h1000, 32'h1, 4'hF, 1'b0);
    checkOutput("filt.pass");

    // Watchdog with retire on every other cycle; counters freeze once expired.
    doReset("wd.reset");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, (i % 2) == 0);
      checkOutput("wd.run");
    end
    check("wd.timeout.const", 64'(bus.timeout), 64'd1);
    check("wd.cycles.const", 64'(bus.cycle_count), 64'd20);
    check("wd.instret.const", 64'(bus.instret_count), 64'd10);
    applyStimulus(1'b1, 32'h1000, 32'h1, 4'hF, 1'b1);
    checkOutput("wd.frozen");

    // Tohost hit in the same cycle the watchdog would expire.
    doReset("race.reset");
    idle(19, 1'b0, "race.idle");
    applyStimulus(1'b1, 32'h1002, 32'h1, 4'hF, 1'b0);
    checkOutput("race.hit");
    check("race.timeout.const", 64'(bus.timeout), 64'd0);

    // Reset part-way through a run, then a normal pass afterwards.
    doReset("mid.start");
    idle(7, 1'b1, "mid.run");
    doReset("mid.reset");
    idle(4, 1'b1, "mid.after");
    applyStimulus(1'b1, 32'h1000, 32'h1, 4'hF, 1'b1);
    checkOutput("mid.pass");

    // Random store traffic biased towards the tohost word.
    for (int run = 0; run < 8; run++) begin
      doReset("rand.reset");
      for (int c = 0; c < 30; c++) begin
        case ($urandom_range(0, 5))
          0, 1:    rAddr = 32'h1000 | 32'($urandom_range(0, 3));
          2:       rAddr = 32'h1004;
          3:       rAddr = 32'h0FFC;
          default: rAddr = $urandom;
        endcase
        case ($urandom_range(0, 3))
          0:       rData = 32'h1;
          1:       rData = $urandom | 32'h1;
          2:       rData = $urandom & 32'hFFFF_FFFE;
          default: rData = $urandom;
        endcase
        rMask = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom_range(0, 15));
        applyStimulus($urandom_range(0, 4) == 0, rAddr, rData, rMask, 1'($urandom_range(0, 1)));
        checkOutput("rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
